// File: rtl/fwd_ctrl.sv
// fwd_ctrl: forwarding and load-use interlock controller for the 3-stage core.
// Tracks the E and W in-flight destination slots. It drives the operand-mux
// selects (00 = regfile, 01 = E ALU result, 10 = W result) and the decode stall.
// Optional feature macro: FWD_CTRL_FORWARDING_EN.
//   defined   -> full E/W bypassing; only load-use hazards stall.
//   undefined -> selects fixed at 00; any RAW dependency on E or W stalls.
// Load handling, the stall counter and w_hold behave the same in both builds.
module fwd_ctrl #(
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int LOAD_STALL_CYCLES = 1   // legal 1..3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rd_d,
    input  logic                      regwrite_d,
    input  logic                      load_d,
    input  logic                      flush,
    output logic [1:0]                fwd_a_sel,
    output logic [1:0]                fwd_b_sel,
    output logic                      stall_d,
    output logic                      w_hold
);

    typedef struct packed {
        logic                      valid;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      regwrite;
        logic                      load;
    } slot_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Counter preload on the hazard edge; WAIT exits on the edge where cnt == 1.
    localparam logic [1:0] CNT_INIT = 2'(LOAD_STALL_CYCLES - 1);
    localparam bit         USE_WAIT = (LOAD_STALL_CYCLES > 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    slot_t      e_q, e_d;
    slot_t      w_q, w_d;

    logic                      e_writer;
    logic                      w_writer;
    logic [REG_ADDR_WIDTH-1:0] rs [2];
    logic [1:0]                match_e;
    logic [1:0]                match_w;
    logic [1:0]                sel [2];
    logic                      in_run;
    logic                      hazard;
    logic                      raw_stall;

    // A slot only produces a value worth forwarding when it writes a non-zero rd.
    assign e_writer = e_q.valid && e_q.regwrite && (e_q.rd != '0);
    assign w_writer = w_q.valid && w_q.regwrite && (w_q.rd != '0);

    assign rs[0] = rs1_d;
    assign rs[1] = rs2_d;

    // Per-operand match and select; the two operands resolve independently.
    // rs = x0 never matches because writers exclude rd = 0.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign match_e[gi] = e_writer && (rs[gi] == e_q.rd);
            assign match_w[gi] = w_writer && (rs[gi] == w_q.rd);
`ifdef FWD_CTRL_FORWARDING_EN
            // E wins over W; a load in E has no ALU result, so fall through to W.
            assign sel[gi] = (match_e[gi] && !e_q.load) ? 2'b01 :
                             match_w[gi]                ? 2'b10 : 2'b00;
`else
            assign sel[gi] = 2'b00;
`endif
        end
    endgenerate

    assign fwd_a_sel = sel[0];
    assign fwd_b_sel = sel[1];

    assign in_run = (state_q == ST_RUN);

    // Load in E feeding the decode instruction: the data is not ready yet.
    assign hazard = in_run && valid_d && !flush && (|match_e) && e_q.load;

`ifdef FWD_CTRL_FORWARDING_EN
    assign raw_stall = 1'b0;
`else
    // Without bypass paths, any dependency on an in-flight writer must wait.
    assign raw_stall = in_run && valid_d && !flush && ((|match_e) || (|match_w));
`endif

    assign stall_d = (state_q == ST_WAIT) || hazard || raw_stall;
    assign w_hold  = (state_q == ST_WAIT);

    // Next-state logic for the FSM, the stall counter and the E/W slots.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        e_d     = '0;
        w_d     = e_q;
        unique case (state_q)
            ST_RUN: begin
                if (hazard) begin
                    // Load advances to W; a bubble goes into E behind it.
                    cnt_d   = CNT_INIT;
                    state_d = USE_WAIT ? ST_WAIT : ST_RUN;
                end else if (valid_d && !stall_d && !flush) begin
                    e_d = {1'b1, rd_d, regwrite_d, load_d};
                end
            end
            ST_WAIT: begin
                // Load stays parked in W; E keeps a bubble.
                w_d   = w_q;
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, counter and slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
            e_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            w_q     <= w_d;
        end
    end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed testbench for fwd_ctrl (LOAD_STALL_CYCLES = 3).
// Expectations follow whichever build is compiled (FWD_CTRL_FORWARDING_EN or not).
module tb_fwd_ctrl;

    logic       clk;
    logic       rst;
    logic       valid_d;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_d;
    logic       regwrite_d;
    logic       load_d;
    logic       flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall_d;
    logic       w_hold;

    int tests_run;
    int tests_failed;

    fwd_ctrl #(
        .REG_ADDR_WIDTH   (5),
        .LOAD_STALL_CYCLES(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_d    (valid_d),
        .rs1_d      (rs1_d),
        .rs2_d      (rs2_d),
        .rd_d       (rd_d),
        .regwrite_d (regwrite_d),
        .load_d     (load_d),
        .flush      (flush),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall_d    (stall_d),
        .w_hold     (w_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one decode instruction and let the combinational outputs settle.
    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic rw, input logic ld, input logic fl);
        valid_d    = v;
        rs1_d      = r1;
        rs2_d      = r2;
        rd_d       = rd;
        regwrite_d = rw;
        load_d     = ld;
        flush      = fl;
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        tests_run++; if (fwd_a_sel !== 2'b00) begin tests_failed++; $display("FAIL reset_sel_a: got %b expected 00", fwd_a_sel); end
        tests_run++; if (fwd_b_sel !== 2'b00) begin tests_failed++; $display("FAIL reset_sel_b: got %b expected 00", fwd_b_sel); end
        tests_run++; if (stall_d !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall_d); end
        tests_run++; if (w_hold !== 1'b0) begin tests_failed++; $display("FAIL reset_w_hold: got %b expected 0", w_hold); end
        @(negedge clk);
        rst = 1'b0;
        step();
        $display("[TB] test_reset done");
    endtask

    // ADD x5 then SUB using x5 as rs1.
    task automatic test_fwd_e();
        logic [1:0] exp_sel;
        logic       exp_stall;
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        tests_run++; if (stall_d !== 1'b0) begin tests_failed++; $display("FAIL fwd_e_producer_stall: got %b expected 0", stall_d); end
        step();
        drive(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0);
`ifdef FWD_CTRL_FORWARDING_EN
        exp_sel = 2'b01; exp_stall = 1'b0;
`else
        exp_sel = 2'b00; exp_stall = 1'b1;
`endif
        tests_run++; if (fwd_a_sel !== exp_sel) begin tests_failed++; $display("FAIL fwd_e_sel_a: got %b expected %b", fwd_a_sel, exp_sel); end
        tests_run++; if (stall_d !== exp_stall) begin tests_failed++; $display("FAIL fwd_e_stall: got %b expected %b", stall_d, exp_stall); end
        tests_run++; if (fwd_b_sel !== 2'b00) begin tests_failed++; $display("FAIL fwd_e_sel_b: got %b expected 00", fwd_b_sel); end
        step();
`ifndef FWD_CTRL_FORWARDING_EN
        // Interlock: producer now in W, still one more stall cycle.
        tests_run++; if (stall_d !== 1'b1) begin tests_failed++; $display("FAIL interlock_stall2: got %b expected 1", stall_d); end
        step();
        tests_run++; if (stall_d !== 1'b0) begin tests_failed++; $display("FAIL interlock_release: got %b expected 0", stall_d); end
        tests_run++; if (fwd_a_sel !== 2'b00) begin tests_failed++; $display("FAIL interlock_sel_a: got %b expected 00", fwd_a_sel); end
        step();
`endif
        drain();
        $display("[TB] test_fwd_e done");
    endtask

    // ADD x5, NOP, then use of x5: value comes from W.
    task automatic test_fwd_w();
        logic [1:0] exp_sel;
        logic       exp_stall;
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd5, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0);
`ifdef FWD_CTRL_FORWARDING_EN
        exp_sel = 2'b10; exp_stall = 1'b0;
`else
        exp_sel = 2'b00; exp_stall = 1'b1;
`endif
        tests_run++; if (fwd_a_sel !== exp_sel) begin tests_failed++; $display("FAIL fwd_w_sel_a: got %b expected %b", fwd_a_sel, exp_sel); end
        tests_run++; if (stall_d !== exp_stall) begin tests_failed++; $display("FAIL fwd_w_stall: got %b expected %b", stall_d, exp_stall); end
        step();
        tests_run++; if (stall_d !== 1'b0) begin tests_failed++; $display("FAIL fwd_w_after: got %b expected 0", stall_d); end
        drain();
        $display("[TB] test_fwd_w done");
    endtask

    // x5 in both E and W: E wins for rs2. Also rs1 = x0 and an x0 producer.
    task automatic test_priority_x0();
        logic [1:0] exp_sel;
        logic       exp_stall;
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);
        tests_run++; if (stall_d !== 1'b0) begin tests_failed++; $display("FAIL prio_second_add_stall: got %b expected 0", stall_d); end
        step();
        drive(1'b1, 5'd0, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0);
`ifdef FWD_CTRL_FORWARDING_EN
        exp_sel = 2'b01; exp_stall = 1'b0;
`else
        exp_sel = 2'b00; exp_stall = 1'b1;
`endif
        tests_run++; if (fwd_b_sel !== exp_sel) begin tests_failed++; $display("FAIL prio_sel_b: got %b expected %b", fwd_b_sel, exp_sel); end
        tests_run++; if (fwd_a_sel !== 2'b00) begin tests_failed++; $display("FAIL prio_x0_sel_a: got %b expected 00", fwd_a_sel); end
        tests_run++; if (stall_d !== exp_stall) begin tests_failed++; $display("FAIL prio_stall: got %b expected %b", stall_d, exp_stall); end
        drain();
        // Producer writing x0 is never a writer.
        drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        tests_run++; if (fwd_a_sel !== 2'b00) begin tests_failed++; $display("FAIL x0_sel_a: got %b expected 00", fwd_a_sel); end
        tests_run++; if (fwd_b_sel !== 2'b00) begin tests_failed++; $display("FAIL x0_sel_b: got %b expected 00", fwd_b_sel); end
        tests_run++; if (stall_d !== 1'b0) begin tests_failed++; $display("FAIL x0_stall: got %b expected 0", stall_d); end
        drain();
        $display("[TB] test_priority_x0 done");
    endtask

    // LW x7 then ADD using x7: three stall cycles, w_hold on cycles 2 and 3.
    task automatic test_load_use();
        logic [1:0] exp_sel;
        logic       exp_stall;
        drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        tests_run++; if (stall_d !== 1'b0) begin tests_failed++; $display("FAIL lu_load_stall: got %b expected 0", stall_d); end
        step();
        drive(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        tests_run++; if (stall_d !== 1'b1) begin tests_failed++; $display("FAIL lu_c1_stall: got %b expected 1", stall_d); end
        tests_run++; if (w_hold !== 1'b0) begin tests_failed++; $display("FAIL lu_c1_w_hold: got %b expected 0", w_hold); end
        step();
        tests_run++; if (stall_d !== 1'b1) begin tests_failed++; $display("FAIL lu_c2_stall: got %b expected 1", stall_d); end
        tests_run++; if (w_hold !== 1'b1) begin tests_failed++; $display("FAIL lu_c2_w_hold: got %b expected 1", w_hold); end
        step();
        tests_run++; if (stall_d !== 1'b1) begin tests_failed++; $display("FAIL lu_c3_stall: got %b expected 1", stall_d); end
        tests_run++; if (w_hold !== 1'b1) begin tests_failed++; $display("FAIL lu_c3_w_hold: got %b expected 1", w_hold); end
        step();
`ifdef FWD_CTRL_FORWARDING_EN
        exp_sel = 2'b10; exp_stall = 1'b0;
`else
        exp_sel = 2'b00; exp_stall = 1'b1;
`endif
        tests_run++; if (stall_d !== exp_stall) begin tests_failed++; $display("FAIL lu_release_stall: got %b expected %b", stall_d, exp_stall); end
        tests_run++; if (fwd_a_sel !== exp_sel) begin tests_failed++; $display("FAIL lu_release_sel_a: got %b expected %b", fwd_a_sel, exp_sel); end
        tests_run++; if (w_hold !== 1'b0) begin tests_failed++; $display("FAIL lu_release_w_hold: got %b expected 0", w_hold); end
        step();
        tests_run++; if (stall_d !== 1'b0) begin tests_failed++; $display("FAIL lu_after_stall: got %b expected 0", stall_d); end
        drain();
        $display("[TB] test_load_use done");
    endtask

    // Load-use pattern with flush on the consumer: no stall, bubble into E.
    task automatic test_flush();
        drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1);
        tests_run++; if (stall_d !== 1'b0) begin tests_failed++; $display("FAIL flush_stall: got %b expected 0", stall_d); end
        step();
        // If the flushed ADD x8 had entered E, this reader of x8 would see it.
        drive(1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tests_run++; if (fwd_a_sel !== 2'b00) begin tests_failed++; $display("FAIL flush_bubble_sel_a: got %b expected 00", fwd_a_sel); end
        tests_run++; if (stall_d !== 1'b0) begin tests_failed++; $display("FAIL flush_bubble_stall: got %b expected 0", stall_d); end
        tests_run++; if (w_hold !== 1'b0) begin tests_failed++; $display("FAIL flush_w_hold: got %b expected 0", w_hold); end
        drain();
        $display("[TB] test_flush done");
    endtask

    // Asynchronous reset in the middle of WAIT.
    task automatic test_rst_mid_wait();
        drive(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 5'd7, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0);
        step();
        tests_run++; if (w_hold !== 1'b1) begin tests_failed++; $display("FAIL rstw_in_wait: got %b expected 1", w_hold); end
        #2;
        rst = 1'b1;
        #1;
        tests_run++; if (fwd_a_sel !== 2'b00) begin tests_failed++; $display("FAIL rstw_sel_a: got %b expected 00", fwd_a_sel); end
        tests_run++; if (fwd_b_sel !== 2'b00) begin tests_failed++; $display("FAIL rstw_sel_b: got %b expected 00", fwd_b_sel); end
        tests_run++; if (stall_d !== 1'b0) begin tests_failed++; $display("FAIL rstw_stall: got %b expected 0", stall_d); end
        tests_run++; if (w_hold !== 1'b0) begin tests_failed++; $display("FAIL rstw_w_hold: got %b expected 0", w_hold); end
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
        tests_run++; if (stall_d !== 1'b0) begin tests_failed++; $display("FAIL rstw_after_stall: got %b expected 0", stall_d); end
        tests_run++; if (w_hold !== 1'b0) begin tests_failed++; $display("FAIL rstw_after_w_hold: got %b expected 0", w_hold); end
        drain();
        $display("[TB] test_rst_mid_wait done");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        valid_d      = 1'b0;
        rs1_d        = '0;
        rs2_d        = '0;
        rd_d         = '0;
        regwrite_d   = 1'b0;
        load_d       = 1'b0;
        flush        = 1'b0;
        test_reset();
        test_fwd_e();
        test_fwd_w();
        test_priority_x0();
        test_load_use();
        test_flush();
        test_rst_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
